guard_anim_ctrl: RTL

- Sequences the guard sprite's walk animation and drives the sprite ROM address and frame select for the guard sprite/palette path.
- Latches guard position, direction and motion once per video frame, then advances the walk step every FRAMES_PER_STEP frames.
- Per pixel, emits the in-sprite ROM address plus a hit flag delayed one cycle so it lines up with the ROM's registered q.
- Sits between game logic (guard FSM/position) and the guard sprite ROM/palette, all on vga_clk.

---
 rtl/guard_anim_ctrl_pkg.sv | 24 ++
 rtl/guard_anim_ctrl_if.sv | 29 ++
 rtl/guard_anim_ctrl_frame_tick.sv | 34 +++
 rtl/guard_anim_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/guard_anim_ctrl_pkg.sv
// Shared types and defaults for the guard sprite animation path.
package guard_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } anim_state_t;

  localparam int unsigned SPR_W_DEFAULT = 21;
  localparam int unsigned SPR_H_DEFAULT = 45;

  // Bit width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/guard_anim_ctrl_if.sv
// Raster, game-state and sprite-ROM signals of the guard animation controller.
interface guard_anim_ctrl_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned SEL_W  = 3
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        guard_x;
  logic [9:0]        guard_y;
  logic [1:0]        dir;
  logic              moving;
  logic              freeze;
  logic              frame_start;
  logic [SEL_W-1:0]  frame_sel;
  logic [ADDR_W-1:0] rom_address;
  logic              sprite_on;

  // Video/game side.
  modport master (
    output DrawX, DrawY, guard_x, guard_y, dir, moving, freeze,
    input  frame_start, frame_sel, rom_address, sprite_on
  );

  // Animation controller side.
  modport slave (
    input  DrawX, DrawY, guard_x, guard_y, dir, moving, freeze,
    output frame_start, frame_sel, rom_address, sprite_on
  );
endinterface

// File: rtl/guard_anim_ctrl_frame_tick.sv
// Registered one-cycle pulse when the raster first reaches pixel (0,0).
module frame_tick_det (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  output logic       frame_start_o
);

  logic origin;
  logic origin_q, origin_d;
  logic frame_start_q, frame_start_d;

  // Rising edge of the origin condition, so a held (0,0) gives only one pulse.
  always_comb begin
    origin        = (draw_x_i == 10'd0) && (draw_y_i == 10'd0);
    origin_d      = origin;
    frame_start_d = origin && !origin_q;
  end

  // Previous-cycle origin flag and the registered pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      origin_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      origin_q      <= origin_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/guard_anim_ctrl.sv
// Guard walk animation sequencer and per-pixel sprite ROM addressing.
module guard_anim_ctrl
  import guard_pkg::*;
#(
  parameter int unsigned SPR_W           = SPR_W_DEFAULT,
  parameter int unsigned SPR_H           = SPR_H_DEFAULT,
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned NUM_STEPS       = 2,
  parameter int unsigned ADDR_W          = 11
) (
  input  logic               vga_clk,
  input  logic               Reset,
  guard_anim_ctrl_if.slave   bus
);

  localparam int unsigned STEP_W = idx_width(NUM_STEPS);
  localparam int unsigned CNT_W  = idx_width(FRAMES_PER_STEP);
  localparam logic [STEP_W-1:0] StepLast = STEP_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(FRAMES_PER_STEP - 1);

  logic              frame_start;
  anim_state_t       state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dir_t              dir_l_q, dir_l_d;
  logic              moving_l_q, moving_l_d;
  logic [9:0]        gx_l_q, gx_l_d;
  logic [9:0]        gy_l_q, gy_l_d;
  logic              sprite_on_q, sprite_on_d;

  logic [9:0]        dx, dy;
  logic              hit;
  logic [19:0]       addr_full;

  frame_tick_det u_tick (
    .clk_i         (vga_clk),
    .rst_i         (Reset),
    .draw_x_i      (bus.DrawX),
    .draw_y_i      (bus.DrawY),
    .frame_start_o (frame_start)
  );

  // Once per frame: shadow-latch game inputs and step the walk FSM unless frozen.
  // Decisions use the values being latched this tick, compared with the old dir_l.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    dir_l_d    = dir_l_q;
    moving_l_d = moving_l_q;
    gx_l_d     = gx_l_q;
    gy_l_d     = gy_l_q;
    if (frame_start) begin
      gx_l_d     = bus.guard_x;
      gy_l_d     = bus.guard_y;
      dir_l_d    = dir_t'(bus.dir);
      moving_l_d = bus.moving;
      if (!bus.freeze) begin
        unique case (state_q)
          IDLE: begin
            step_d = '0;
            cnt_d  = '0;
            if (bus.moving) state_d = WALK;
          end
          WALK: begin
            if (!bus.moving) begin
              state_d = IDLE;
              step_d  = '0;
              cnt_d   = '0;
            end else if (dir_t'(bus.dir) != dir_l_q) begin
              // Turning restarts the cycle; beats a coincident terminal count.
              step_d = '0;
              cnt_d  = '0;
            end else if (cnt_q == CntLast) begin
              cnt_d  = '0;
              step_d = (step_q == StepLast) ? '0 : step_q + 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Hit test against the latched box; left/above pixels wrap to large offsets and miss.
  always_comb begin
    dx          = bus.DrawX - gx_l_q;
    dy          = bus.DrawY - gy_l_q;
    hit         = (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
    addr_full   = 20'(dy) * 20'(SPR_W) + 20'(dx);
    sprite_on_d = hit;
  end

  // State, shadow latches and the hit flag aligned with the ROM's registered q.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      dir_l_q     <= DIR_DOWN;
      moving_l_q  <= 1'b0;
      gx_l_q      <= '0;
      gy_l_q      <= '0;
      sprite_on_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      dir_l_q     <= dir_l_d;
      moving_l_q  <= moving_l_d;
      gx_l_q      <= gx_l_d;
      gy_l_q      <= gy_l_d;
      sprite_on_q <= sprite_on_d;
    end
  end

  // moving_l is kept as latched game state; the FSM acts on the value at the tick.
  logic unused_moving_l;
  assign unused_moving_l = moving_l_q;

  assign bus.frame_start = frame_start;
  assign bus.frame_sel   = {dir_l_q, step_q};
  assign bus.rom_address = hit ? addr_full[ADDR_W-1:0] : '0;
  assign bus.sprite_on   = sprite_on_q;

endmodule
